mem_access: RTL

//  Memory stage, directly downstream of the execute/ALU stage. Takes the effective address (ALU result), store data
//  and funct3 of LOAD/STORE instructions, runs one req/ack transaction on the data-memory port, aligns and

---
 rtl/mem_access_pkg.sv | 71 +++++++
 rtl/mem_align.sv | 45 ++++
 rtl/mem_access.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared encodings for the memory stage.
//               Covers opcode one-hot positions, exception bit indices,
//               funct3 size codes, FSM states and the size helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

    localparam int OPCODE_WIDTH    = 11;
    localparam int EXCEPTION_WIDTH = 16;

    localparam int OP_LUI    = 0;
    localparam int OP_AUIPC  = 1;
    localparam int OP_JAL    = 2;
    localparam int OP_JALR   = 3;
    localparam int OP_BRANCH = 4;
    localparam int OP_LOAD   = 5;
    localparam int OP_STORE  = 6;
    localparam int OP_OPIMM  = 7;
    localparam int OP_OP     = 8;
    localparam int OP_FENCE  = 9;
    localparam int OP_SYSTEM = 10;

    localparam logic [OPCODE_WIDTH-1:0] OPC_LOAD  = OPCODE_WIDTH'(1) << OP_LOAD;
    localparam logic [OPCODE_WIDTH-1:0] OPC_STORE = OPCODE_WIDTH'(1) << OP_STORE;
    localparam logic [OPCODE_WIDTH-1:0] OPC_ALU   = OPCODE_WIDTH'(1) << OP_OP;

    localparam int EXC_LOAD_ADDR_MISALIGNED  = 4;
    localparam int EXC_LOAD_ACCESS_FAULT     = 5;
    localparam int EXC_STORE_ADDR_MISALIGNED = 6;
    localparam int EXC_STORE_ACCESS_FAULT    = 7;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unused funct3 codes (011/110/111) fall through to word access.
    function automatic size_e size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (size_of(f3))
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_align
// Description : Byte-enable generation, store lane replication and load
//               extraction with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted   = i_rdata >> {i_addr_lo, 3'b000};
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = w_shifted;
        case (size_of(i_funct3))
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_store_data[7:0]}};
                o_load_data = i_funct3[2] ? {24'b0, w_shifted[7:0]}
                                          : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SZ_HALF: begin
                o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata     = {2{i_store_data[15:0]}};
                o_load_data = i_funct3[2] ? {16'b0, w_shifted[15:0]}
                                          : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module      : mem_access
// Description : Memory pipeline stage; one req/ack data-memory transaction
//               per load/store, aligned load writeback, 1-cycle pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prev_clk_en,
    input  logic [OPCODE_WIDTH-1:0]    prev_opcode_type,
    input  logic [2:0]                 prev_funct3,
    input  logic [31:0]                prev_alu_result,
    input  logic [31:0]                prev_rs2_data,
    input  logic [4:0]                 prev_rd,
    input  logic                       prev_rd_w_en,
    input  logic [31:0]                prev_rd_wdata,
    input  logic [EXCEPTION_WIDTH-1:0] prev_exception,
    input  logic                       prev_stall,
    input  logic                       prev_flush,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [31:0]                dmem_addr,
    output logic [3:0]                 dmem_be,
    output logic [31:0]                dmem_wdata,
    input  logic                       dmem_ack,
    input  logic [31:0]                dmem_rdata,
    output logic [4:0]                 rd,
    output logic                       rd_w_en,
    output logic [31:0]                rd_wdata,
    output logic [EXCEPTION_WIDTH-1:0] exception,
    output logic                       clk_en,
    output logic                       stall
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       dmem_req_q, dmem_req_d, dmem_we_q, dmem_we_d;
    logic [31:0]                dmem_addr_q, dmem_addr_d, dmem_wdata_q, dmem_wdata_d;
    logic [3:0]                 dmem_be_q, dmem_be_d;
    logic [4:0]                 rd_q, rd_d, pend_rd_q, pend_rd_d;
    logic                       rd_w_en_q, rd_w_en_d, pend_rd_w_en_q, pend_rd_w_en_d;
    logic [31:0]                rd_wdata_q, rd_wdata_d;
    logic [EXCEPTION_WIDTH-1:0] exception_q, exception_d, pend_exc_q, pend_exc_d;
    logic                       clk_en_q, clk_en_d;
    logic [2:0]                 pend_funct3_q, pend_funct3_d;
    logic [1:0]                 pend_lo_q, pend_lo_d;

    logic        w_stall, w_accept, w_is_load, w_is_store, w_misal, w_timeout;
    logic [2:0]  w_al_funct3;
    logic [1:0]  w_al_lo;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;

    // Issue uses the incoming instruction; completion uses the captured one.
    assign w_al_funct3 = (state_q == ST_IDLE) ? prev_funct3 : pend_funct3_q;
    assign w_al_lo     = (state_q == ST_IDLE) ? prev_alu_result[1:0] : pend_lo_q;

    mem_align u_align (
        .i_funct3     (w_al_funct3),
        .i_addr_lo    (w_al_lo),
        .i_store_data (prev_rs2_data),
        .i_rdata      (dmem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign w_stall    = (state_q != ST_IDLE) | prev_stall;
    assign w_accept   = prev_clk_en & ~w_stall;
    assign w_is_load  = (prev_opcode_type == OPC_LOAD);
    assign w_is_store = (prev_opcode_type == OPC_STORE);
    assign w_misal    = is_misaligned(prev_funct3, prev_alu_result[1:0]);
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        dmem_req_d     = dmem_req_q;
        dmem_we_d      = dmem_we_q;
        dmem_addr_d    = dmem_addr_q;
        dmem_be_d      = dmem_be_q;
        dmem_wdata_d   = dmem_wdata_q;
        rd_d           = rd_q;
        rd_w_en_d      = rd_w_en_q;
        rd_wdata_d     = rd_wdata_q;
        exception_d    = exception_q;
        clk_en_d       = clk_en_q;
        pend_rd_d      = pend_rd_q;
        pend_rd_w_en_d = pend_rd_w_en_q;
        pend_exc_d     = pend_exc_q;
        pend_funct3_d  = pend_funct3_q;
        pend_lo_d      = pend_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (prev_flush) begin
                        clk_en_d = 1'b0;
                    end else if ((w_is_load || w_is_store) && !w_misal) begin
                        dmem_req_d     = 1'b1;
                        dmem_we_d      = w_is_store;
                        dmem_addr_d    = {prev_alu_result[31:2], 2'b00};
                        dmem_be_d      = w_be;
                        dmem_wdata_d   = w_wdata;
                        pend_rd_d      = prev_rd;
                        pend_rd_w_en_d = prev_rd_w_en;
                        pend_exc_d     = prev_exception;
                        pend_funct3_d  = prev_funct3;
                        pend_lo_d      = prev_alu_result[1:0];
                        cnt_d          = '0;
                        clk_en_d       = 1'b0;
                        state_d        = ST_WAIT;
                    end else begin
                        rd_d        = prev_rd;
                        rd_w_en_d   = prev_rd_w_en;
                        rd_wdata_d  = prev_rd_wdata;
                        exception_d = prev_exception;
                        clk_en_d    = 1'b1;
                        if (w_is_store) begin
                            rd_w_en_d = 1'b0;
                            exception_d[EXC_STORE_ADDR_MISALIGNED] = 1'b1;
                        end else if (w_is_load) begin
                            rd_w_en_d = 1'b0;
                            exception_d[EXC_LOAD_ADDR_MISALIGNED] = 1'b1;
                        end
                    end
                end else if (!prev_stall) begin
                    clk_en_d = 1'b0;
                end
            end
            ST_WAIT: begin
                // Ack takes priority over a timeout landing in the same cycle.
                if (dmem_ack || w_timeout) begin
                    dmem_req_d  = 1'b0;
                    rd_d        = pend_rd_q;
                    exception_d = pend_exc_q;
                    if (dmem_ack) begin
                        rd_w_en_d  = pend_rd_w_en_q & ~dmem_we_q;
                        rd_wdata_d = dmem_we_q ? 32'h0 : w_load_data;
                    end else begin
                        rd_w_en_d  = 1'b0;
                        rd_wdata_d = 32'h0;
                        if (dmem_we_q) exception_d[EXC_STORE_ACCESS_FAULT] = 1'b1;
                        else           exception_d[EXC_LOAD_ACCESS_FAULT]  = 1'b1;
                    end
                    if (prev_stall) begin
                        state_d = ST_DONE;
                    end else begin
                        clk_en_d = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (!prev_stall) begin
                    clk_en_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            dmem_req_q     <= 1'b0;
            dmem_we_q      <= 1'b0;
            dmem_addr_q    <= '0;
            dmem_be_q      <= '0;
            dmem_wdata_q   <= '0;
            rd_q           <= '0;
            rd_w_en_q      <= 1'b0;
            rd_wdata_q     <= '0;
            exception_q    <= '0;
            clk_en_q       <= 1'b0;
            pend_rd_q      <= '0;
            pend_rd_w_en_q <= 1'b0;
            pend_exc_q     <= '0;
            pend_funct3_q  <= '0;
            pend_lo_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req_q     <= dmem_req_d;
            dmem_we_q      <= dmem_we_d;
            dmem_addr_q    <= dmem_addr_d;
            dmem_be_q      <= dmem_be_d;
            dmem_wdata_q   <= dmem_wdata_d;
            rd_q           <= rd_d;
            rd_w_en_q      <= rd_w_en_d;
            rd_wdata_q     <= rd_wdata_d;
            exception_q    <= exception_d;
            clk_en_q       <= clk_en_d;
            pend_rd_q      <= pend_rd_d;
            pend_rd_w_en_q <= pend_rd_w_en_d;
            pend_exc_q     <= pend_exc_d;
            pend_funct3_q  <= pend_funct3_d;
            pend_lo_q      <= pend_lo_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign rd         = rd_q;
    assign rd_w_en    = rd_w_en_q;
    assign rd_wdata   = rd_wdata_q;
    assign exception  = exception_q;
    assign clk_en     = clk_en_q;
    assign stall      = w_stall;

endmodule
`default_nettype wire
